alu8_seq_unit: RTL and testbench
================================

Name: alu8_seq_unit

Overview:
- Sequencing front end for the 8-bit ALU datapath. It accepts an operation command over a valid/ready handshake and drives operands into the bitwise and arithmetic logic.
- It runs multi-cycle shifts one bit per cycle, then registers the result and flags. The result is held until the downstream consumer accepts it.
- Sits between the instruction/control path (producer) and the register write-back path (consumer).

Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  unit can accept a command.
- cmd_op  input  3  opcode.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B; for shifts, B[2:0] is the shift amount.
- res_valid  output  1  result held and valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  8  result.
- res_zero  output  1  res_data == 0.
- res_neg  output  1  res_data[7].
- res_carry  output  1  carry/borrow/shift-out.
- res_err  output  1  illegal opcode.
- op_count  output  CNT_W  completed (accepted) results, wraps.

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values: state IDLE, cmd_ready=1 once state is IDLE, res_valid=0, res_data=0, all flags=0, op_count=0, internal operand and shift-count registers=0.
- Reset mid-operation aborts the command. The result is discarded and no count is taken.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NAND: bitwise, carry=0.
  - 100 ADD: 9-bit sum, carry=bit 8.
  - 101 SUB: A-B mod 256, carry=1 when A<B (borrow).
  - 110 SHL: logical shift left by B[2:0].
  - 111 SHR: logical shift right by B[2:0].
  - No illegal opcodes with the 3-bit field; res_err is tied to a decode check and is 0 for all eight codes. It is reserved for future expansion and the bench checks it stays 0.
- Handshake: cmd_ready = (state==IDLE). A command is accepted on the edge where cmd_valid && cmd_ready. Operands and opcode are latched; cmd_* inputs are ignored at all other times.
- States:
  - IDLE: on accept, go to EXEC for opcodes 000-101 and to SHIFT for 110/111, with shift_cnt=B[2:0] and the working register loaded with A.
  - EXEC: one edge; compute, register res_data and flags, go to DONE.
  - SHIFT: while shift_cnt!=0, each edge shifts the working register by 1, records the bit shifted out as carry, and decrements shift_cnt. When shift_cnt==0 the next edge registers the result and flags and goes to DONE. For amount 0, result=A and carry=0.
  - DONE: res_valid=1 and outputs stable. On the edge with res_ready=1, go to IDLE, clear res_valid and increment op_count. res_data and flags keep their last value after leaving DONE.
- Latency from accept edge to res_valid high:
  - Non-shift ops: 2 edges.
  - Shifts: k+2 edges for amount k (0..7).
- Throughput: one command per (latency+1) cycles minimum, because there is no command overlap with DONE.
- res_ready asserted outside DONE has no effect. cmd_valid held high while busy is simply stalled.
- Flags: res_zero and res_neg are derived from the registered result and updated only on the result-register edge.
- op_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package alu8_pkg:
  - Opcode constants OP_AND..OP_SHR (3 bits).
  - State encoding constants ST_IDLE, ST_EXEC, ST_SHIFT, ST_DONE (2 bits).
- Sub-module logic8_core (combinational): takes A, B and op[1:0] and returns the bitwise AND/OR/XOR/NAND result. Instantiated once; the add/sub and shift logic stays in the top module.

Test Plan:
- After rst pulse: cmd_ready=1, res_valid=0, res_data=0, op_count=0. Then AND A=0xF0, B=0x3C with res_ready=1 -> res_valid 2 edges after accept, res_data=0x30, zero=0, neg=0, carry=0, op_count=1.
- ADD 0xFF+0x01 -> res_data=0x00, zero=1, carry=1. SUB 0x05-0x07 -> res_data=0xFE, neg=1, carry=1.
- SHL A=0x81, B=0x03 -> res_valid exactly 5 edges after accept, res_data=0x08, carry=0. SHR A=0x81, B=0x01 -> res_data=0x40, carry=1, latency 3. SHL amount 0 -> res_data=A, carry=0, latency 2.
- Backpressure: XOR 0xAA^0x55 with res_ready=0 for 10 cycles -> res_valid stays 1, res_data=0xFF stable, cmd_ready=0, a second cmd_valid is not accepted. Releasing res_ready -> IDLE next edge, op_count increments exactly once.
- Reset mid-SHIFT (amount 7, rst asserted after 3 shift edges, asynchronously between edges) -> outputs zero immediately, op_count unchanged at 0. The next command completes normally.
- Issue 2^CNT_W+3 commands (CNT_W overridden to 4) -> op_count wraps and reads 3.

Source files
------------

// File: rtl/alu8_pkg.sv
// Shared opcode and state encodings for the 8-bit ALU sequencing front end.
package alu8_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Every 3-bit code is currently defined; the default arm is kept for a wider opcode field.
    function automatic logic op_is_legal(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NAND,
            OP_ADD, OP_SUB, OP_SHL, OP_SHR: op_is_legal = 1'b1;
            default:                        op_is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_shift(input logic [2:0] op);
        op_is_shift = (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu8_logic8_core.sv
// Combinational bitwise unit: AND / OR / XOR / NAND selected by op[1:0].
module logic8_core
    import alu8_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [1:0] i_op,
    output logic [7:0] o_y
);

    always_comb begin
        o_y = 8'h00;
        case (i_op)
            OP_AND[1:0]:  o_y = i_a & i_b;
            OP_OR[1:0]:   o_y = i_a | i_b;
            OP_XOR[1:0]:  o_y = i_a ^ i_b;
            OP_NAND[1:0]: o_y = ~(i_a & i_b);
            default:      o_y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu8_seq_unit.sv
// Sequencing front end for the 8-bit ALU: latches a command, runs one-bit-per-cycle
// shifts, and holds the registered result until the consumer accepts it.
module alu8_seq_unit
    import alu8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_carry,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both
    // high; cmd_ready is high only in IDLE, res_valid only in DONE.

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_op;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [7:0]         r_work;
    logic [2:0]         r_cnt;
    logic               r_sc;
    logic [7:0]         r_res;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_err;
    logic [CNT_W-1:0]   r_count;

    logic [7:0]         w_logic;
    logic [8:0]         w_sum;
    logic [8:0]         w_diff;
    logic [7:0]         w_exec_res;
    logic               w_exec_carry;
    logic               w_accept;

    logic8_core u_logic8_core (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op[1:0]),
        .o_y  (w_logic)
    );

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
    // Bit 8 of the 9-bit difference is the borrow, i.e. A < B.
    assign w_diff   = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_exec_res   = w_logic;
        w_exec_carry = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_exec_res   = w_sum[7:0];
                w_exec_carry = w_sum[8];
            end
            OP_SUB: begin
                w_exec_res   = w_diff[7:0];
                w_exec_carry = w_diff[8];
            end
            default: begin
                w_exec_res   = w_logic;
                w_exec_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (cmd_valid) w_state_nxt = op_is_shift(cmd_op) ? ST_SHIFT : ST_EXEC;
            ST_EXEC:  w_state_nxt = ST_DONE;
            ST_SHIFT: if (r_cnt == 3'd0) w_state_nxt = ST_DONE;
            ST_DONE:  if (res_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= 3'd0;
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_work  <= 8'h00;
            r_cnt   <= 3'd0;
            r_sc    <= 1'b0;
            r_res   <= 8'h00;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_a    <= cmd_a;
                        r_b    <= cmd_b;
                        r_work <= cmd_a;
                        r_cnt  <= cmd_b[2:0];
                        r_sc   <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_res   <= w_exec_res;
                    r_carry <= w_exec_carry;
                    r_zero  <= (w_exec_res == 8'h00);
                    r_neg   <= w_exec_res[7];
                    r_err   <= !op_is_legal(r_op);
                end
                ST_SHIFT: begin
                    if (r_cnt != 3'd0) begin
                        // The last bit shifted out becomes the carry flag.
                        if (r_op == OP_SHL) begin
                            r_work <= {r_work[6:0], 1'b0};
                            r_sc   <= r_work[7];
                        end else begin
                            r_work <= {1'b0, r_work[7:1]};
                            r_sc   <= r_work[0];
                        end
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_res   <= r_work;
                        r_carry <= r_sc;
                        r_zero  <= (r_work == 8'h00);
                        r_neg   <= r_work[7];
                        r_err   <= !op_is_legal(r_op);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_DONE);
    assign res_data  = r_res;
    assign res_zero  = r_zero;
    assign res_neg   = r_neg;
    assign res_carry = r_carry;
    assign res_err   = r_err;
    assign op_count  = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu8_seq_unit.sv
// Directed-vector bench for alu8_seq_unit with a queue-based scoreboard and result monitor.
module tb_alu8_seq_unit;
    import alu8_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [7:0]       cmd_a = 8'h00;
    logic [7:0]       cmd_b = 8'h00;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [7:0]       res_data;
    logic             res_zero;
    logic             res_neg;
    logic             res_carry;
    logic             res_err;
    logic [CNT_W-1:0] op_count;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Expected entry: {latency[3:0], err, carry, neg, zero, data[7:0]}
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic        prev_valid = 1'b0;
    logic [15:0] mon_e;
    int          mon_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu8_seq_unit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .res_carry (res_carry),
        .res_err   (res_err),
        .op_count  (op_count),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each rising res_valid, pop the expected entry and compare.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got data 0x%0h with empty queue", res_data);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    check("res_data",  {8'h00, res_data}, {8'h00, mon_e[7:0]});
                    check("res_zero",  {15'd0, res_zero},  {15'd0, mon_e[8]});
                    check("res_neg",   {15'd0, res_neg},   {15'd0, mon_e[9]});
                    check("res_carry", {15'd0, res_carry}, {15'd0, mon_e[10]});
                    check("res_err",   {15'd0, res_err},   {15'd0, mon_e[11]});
                    check("latency",   16'(cyc - mon_acc + 1), {12'd0, mon_e[15:12]});
                end
            end
            prev_valid = res_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, input logic z, input logic n, input logic c,
                         input logic [3:0] lat);
        int budget;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        budget    = 0;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: cmd_ready got 0 required 1");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back({lat, 1'b0, c, n, z, d});
            acc_q.push_back(cyc);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: cmd_ready got 0 required 1");
        end else begin
            exp_cnt++;
            check("op_count", 16'(op_count), 16'(exp_cnt));
            check("queue_drained", 16'(exp_q.size()), 16'd0);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] d, input logic z, input logic n, input logic c,
                       input logic [3:0] lat);
        issue(op, a, b, d, z, n, c, lat);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] va;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_res_valid", {15'd0, res_valid}, 16'd0);
        check("rst_res_data",  {8'd0, res_data},   16'd0);
        check("rst_op_count",  16'(op_count),      16'd0);
        check("rst_flags", {12'd0, res_zero, res_neg, res_carry, res_err}, 16'd0);
        rst = 1'b0;

        //  op       A      B      data   z     n     c     lat
        run(OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 4'd2);
        run(OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 4'd2);
        run(OP_SUB,  8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b1, 4'd2);
        run(OP_SHL,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 4'd5);
        run(OP_SHR,  8'h81, 8'h01, 8'h40, 1'b0, 1'b0, 1'b1, 4'd3);
        run(OP_SHL,  8'h9C, 8'hF8, 8'h9C, 1'b0, 1'b1, 1'b0, 4'd2);
        run(OP_OR,   8'h0F, 8'h80, 8'h8F, 1'b0, 1'b1, 1'b0, 4'd2);
        run(OP_NAND, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2);
        run(OP_SUB,  8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2);
        run(OP_SHR,  8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 4'd9);
        run(OP_SHL,  8'h01, 8'h07, 8'h80, 1'b0, 1'b1, 1'b0, 4'd9);
        run(OP_SHR,  8'h03, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 4'd4);

        // Backpressure: result held while res_ready is low; a second command must stall.
        res_ready = 1'b0;
        issue(OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_AND;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_valid", {15'd0, res_valid}, 16'd1);
            check("bp_res_data",  {8'd0, res_data},   16'h00FF);
            check("bp_cmd_ready", {15'd0, cmd_ready}, 16'd0);
            check("bp_op_count",  16'(op_count),      16'(exp_cnt));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt++;
        check("bp_release_idle",  {15'd0, cmd_ready}, 16'd1);
        check("bp_release_count", 16'(op_count),      16'(exp_cnt));
        repeat (5) @(negedge clk);
        check("bp_no_stray_cmd",  {15'd0, res_valid}, 16'd0);
        check("bp_count_once",    16'(op_count),      16'(exp_cnt));
        check("bp_hold_data",     {8'd0, res_data},   16'h00FF);

        // Abort a 7-bit shift after three shift edges with an asynchronous reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        exp_q.delete();
        acc_q.delete();
        issue(OP_SHL, 8'hFF, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_res_valid", {15'd0, res_valid}, 16'd0);
        check("abort_res_data",  {8'd0, res_data},   16'd0);
        check("abort_op_count",  16'(op_count),      16'd0);
        check("abort_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("abort_state",     {14'd0, dbg_state}, 16'(ST_IDLE));
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run(OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 4'd2);

        // Counter wrap: 1 done above plus 18 here gives 19 = 16 + 3.
        for (int i = 0; i < 18; i++) begin
            va = 8'(i * 15 + 1);
            run(OP_AND, va, 8'hFF, va, (va == 8'h00), va[7], 1'b0, 4'd2);
        end
        check("wrap_op_count", 16'(op_count), 16'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
